imm_gen_pipe: RTL and testbench

Registered, flow-controlled immediate generator for the decode stage. It accepts the instruction's upper 25 bits (instruction bits 31:7) together with a format select. It emits the architecturally correct immediate, sign- or zero-extended to XLEN, through a one-cycle valid/ready stage with a skid buffer. This lets decode stall on backpressure from execute without losing or duplicating immediates. It adds CSR-zimm and shift-amount formats, full XLEN=64 support, a pass-through tag and an illegal-shamt flag.

---
 rtl/imm_gen_pipe_if.sv | 28 ++
 rtl/imm_gen_pipe.sv | 127 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - request/response bundle for the immediate generator stage
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_immed;
    logic [2:0]       in_imm_ctrl;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm_ext;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    // Decode/execute side that drives requests and consumes results.
    modport master (
        output in_valid, in_immed, in_imm_ctrl, in_tag, out_ready,
        input  in_ready, out_valid, out_imm_ext, out_tag, out_err
    );

    // The immediate generator itself.
    modport slave (
        input  in_valid, in_immed, in_imm_ctrl, in_tag, out_ready,
        output in_ready, out_valid, out_imm_ext, out_tag, out_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with one-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    imm_gen_pipe_if.slave bus
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e           state_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_err_q;
    logic [XLEN-1:0]  skid_imm_q;
    logic [TAG_W-1:0] skid_tag_q;
    logic             skid_err_q;

    logic [24:0]      im;
    logic [63:0]      ext64_d;
    logic [XLEN-1:0]  imm_d;
    logic             err_d;
    logic             skid_valid;
    logic             in_hs;
    logic             out_hs;

    assign im = bus.in_immed;

    // Build every format at 64 bits and truncate, so U-type sign extension
    // needs no zero-width replication when XLEN is 32.
    always_comb begin
        ext64_d = '0;
        err_d   = 1'b0;
        case (bus.in_imm_ctrl)
            3'd0: ext64_d = {{52{im[24]}}, im[24:13]};
            3'd1: ext64_d = {{52{im[24]}}, im[24:18], im[4:0]};
            3'd2: ext64_d = {{51{im[24]}}, im[24], im[0], im[23:18], im[4:1], 1'b0};
            3'd3: ext64_d = {{32{im[24]}}, im[24:5], 12'b0};
            3'd4: ext64_d = {{43{im[24]}}, im[24], im[12:5], im[13], im[23:14], 1'b0};
            3'd5: ext64_d = {59'b0, im[12:8]};
            3'd6: begin
                if (XLEN == 64) begin
                    ext64_d = {58'b0, im[18:13]};
                end else begin
                    ext64_d = {59'b0, im[17:13]};
                    err_d   = im[18];
                end
            end
            default: begin
                ext64_d = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    assign imm_d = ext64_d[XLEN-1:0];

    assign skid_valid      = (state_q == S_FULL);
    assign bus.in_ready    = ~skid_valid & ~rst;
    assign bus.out_valid   = (state_q != S_EMPTY);
    assign bus.out_imm_ext = out_imm_q;
    assign bus.out_tag     = out_tag_q;
    assign bus.out_err     = out_err_q;

    assign in_hs  = bus.in_valid & bus.in_ready;
    assign out_hs = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            out_err_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_hs) begin
                        out_imm_q <= imm_d;
                        out_tag_q <= bus.in_tag;
                        out_err_q <= err_d;
                        state_q   <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_hs && out_hs) begin
                        out_imm_q <= imm_d;
                        out_tag_q <= bus.in_tag;
                        out_err_q <= err_d;
                    end else if (in_hs) begin
                        // Downstream stalled: park the new item behind the held one.
                        skid_imm_q <= imm_d;
                        skid_tag_q <= bus.in_tag;
                        skid_err_q <= err_d;
                        state_q    <= S_FULL;
                    end else if (out_hs) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_hs) begin
                        out_imm_q <= skid_imm_q;
                        out_tag_q <= skid_tag_q;
                        out_err_q <= skid_err_q;
                        state_q   <= S_ONE;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed vector bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [24:0] in_immed;
    logic [2:0]  in_ctrl;
    logic [7:0]  in_tag;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) b32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) b64 ();

    assign b32.in_valid    = in_valid;
    assign b32.in_immed    = in_immed;
    assign b32.in_imm_ctrl = in_ctrl;
    assign b32.in_tag      = in_tag;
    assign b32.out_ready   = out_ready;
    assign b64.in_valid    = in_valid;
    assign b64.in_immed    = in_immed;
    assign b64.in_imm_ctrl = in_ctrl;
    assign b64.in_tag      = in_tag;
    assign b64.out_ready   = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u32 (.clk(clk), .rst(rst), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u64 (.clk(clk), .rst(rst), .bus(b64));

    typedef struct {
        logic [2:0]  ctrl;
        logic [24:0] immed;
        logic [31:0] exp32;
        logic        err32;
        logic [63:0] exp64;
        logic        err64;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_i(input logic [24:0] im);
        logic signed [11:0] s;
        s = im[24:13];
        return 64'(s);
    endfunction

    logic [7:0]  exp_tag_q[$];
    logic [63:0] exp_imm_q[$];
    logic [7:0]  got_tag_q[$];
    logic        accepted;
    logic        ready_ok;
    int          first_cyc;
    int          last_cyc;
    int          n_out;
    int          seen_valid;

    initial begin
        vecs[0]  = '{3'd0, 25'h1FFE001, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{3'd2, 25'h1FC001D, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[2]  = '{3'd3, 25'h02468A0, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
        vecs[3]  = '{3'd3, 25'h1000000, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
        vecs[4]  = '{3'd4, 25'h0000020, 32'h00001000, 1'b0, 64'h0000000000001000, 1'b0};
        vecs[5]  = '{3'd5, 25'h0001F00, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
        vecs[6]  = '{3'd6, 25'h0046000, 32'h00000003, 1'b1, 64'h0000000000000023, 1'b0};
        vecs[7]  = '{3'd7, 25'h1FFFFFF, 32'h00000000, 1'b0, 64'h0000000000000000, 1'b0};
        vecs[8]  = '{3'd1, 25'h0040005, 32'h00000025, 1'b0, 64'h0000000000000025, 1'b0};
        vecs[9]  = '{3'd6, 25'h003E000, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0};
        vecs[10] = '{3'd0, 25'h0FFE000, 32'h000007FF, 1'b0, 64'h00000000000007FF, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_immed = '0; in_ctrl = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) edge1();
        chk("rst_in_ready32", 64'(b32.in_ready), 64'd0);
        chk("rst_out_valid32", 64'(b32.out_valid), 64'd0);
        chk("rst_imm32", 64'(b32.out_imm_ext), 64'd0);
        chk("rst_tag32", 64'(b32.out_tag), 64'd0);
        chk("rst_err32", 64'(b32.out_err), 64'd0);
        chk("rst_out_valid64", 64'(b64.out_valid), 64'd0);
        chk("rst_imm64", b64.out_imm_ext, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(b32.in_ready), 64'd1);

        // Decode table: one request, result must be visible the following cycle.
        for (int i = 0; i < 11; i++) begin
            edge1();
            in_valid = 1'b1; in_ctrl = vecs[i].ctrl; in_immed = vecs[i].immed; in_tag = 8'(i + 8'h40);
            edge1();
            in_valid = 1'b0; in_immed = '0; in_ctrl = '0;
            chk($sformatf("v%0d_valid32", i), 64'(b32.out_valid), 64'd1);
            chk($sformatf("v%0d_imm32", i), 64'(b32.out_imm_ext), 64'(vecs[i].exp32));
            chk($sformatf("v%0d_err32", i), 64'(b32.out_err), 64'(vecs[i].err32));
            chk($sformatf("v%0d_tag32", i), 64'(b32.out_tag), 64'(i + 8'h40));
            chk($sformatf("v%0d_imm64", i), b64.out_imm_ext, vecs[i].exp64);
            chk($sformatf("v%0d_err64", i), 64'(b64.out_err), 64'(vecs[i].err64));
        end
        edge1();
        chk("drain_empty", 64'(b32.out_valid), 64'd0);

        // Backpressure: three requests against a stalled consumer.
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 3'd0; in_immed = 25'(1) << 13; in_tag = 8'd1;
        edge1();
        chk("bp_ready_after1", 64'(b32.in_ready), 64'd1);
        in_immed = 25'(2) << 13; in_tag = 8'd2;
        edge1();
        in_immed = 25'(3) << 13; in_tag = 8'd3;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp_in_ready_low%0d", c), 64'(b32.in_ready), 64'd0);
            chk($sformatf("bp_hold_valid%0d", c), 64'(b32.out_valid), 64'd1);
            chk($sformatf("bp_hold_tag%0d", c), 64'(b32.out_tag), 64'd1);
            chk($sformatf("bp_hold_imm%0d", c), 64'(b32.out_imm_ext), 64'd1);
            edge1();
        end
        out_ready = 1'b1;
        got_tag_q.delete();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            accepted = in_valid & b32.in_ready;
            if (b32.out_valid) begin
                got_tag_q.push_back(b32.out_tag);
                chk($sformatf("bp_imm_tag%0d", b32.out_tag), 64'(b32.out_imm_ext), 64'(b32.out_tag));
            end
            edge1();
            if (accepted) in_valid = 1'b0;
        end
        chk("bp_count", 64'(got_tag_q.size()), 64'd3);
        if (got_tag_q.size() == 3) begin
            chk("bp_order0", 64'(got_tag_q[0]), 64'd1);
            chk("bp_order1", 64'(got_tag_q[1]), 64'd2);
            chk("bp_order2", 64'(got_tag_q[2]), 64'd3);
        end

        // Streaming: one request per cycle with the consumer always ready.
        exp_tag_q.delete(); exp_imm_q.delete();
        ready_ok = 1'b1; n_out = 0; first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 19; c++) begin
            if (c < 16) begin
                in_valid = 1'b1; in_ctrl = 3'd0;
                in_immed = 25'($urandom); in_tag = 8'(8'h80 + c);
                exp_tag_q.push_back(in_tag);
                exp_imm_q.push_back(model_i(in_immed));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && !b32.in_ready) ready_ok = 1'b0;
            if (b32.out_valid) begin
                n_out++;
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                if (exp_tag_q.size() == 0) begin
                    chk("st_extra", 64'(b32.out_tag), 64'hFFFF);
                end else begin
                    chk($sformatf("st_tag%0d", n_out), 64'(b32.out_tag), 64'(exp_tag_q[0]));
                    chk($sformatf("st_imm32_%0d", n_out), 64'(b32.out_imm_ext), 64'(exp_imm_q[0][31:0]));
                    chk($sformatf("st_imm64_%0d", n_out), b64.out_imm_ext, exp_imm_q[0]);
                    void'(exp_tag_q.pop_front());
                    void'(exp_imm_q.pop_front());
                end
            end
            edge1();
        end
        chk("st_ready_const", 64'(ready_ok), 64'd1);
        chk("st_count", 64'(n_out), 64'd16);
        chk("st_back_to_back", 64'(last_cyc - first_cyc), 64'd15);

        // Reset while FULL must discard both held items.
        out_ready = 1'b0;
        in_valid = 1'b1; in_ctrl = 3'd0; in_immed = 25'(5) << 13; in_tag = 8'hA0;
        edge1();
        in_tag = 8'hA1;
        edge1();
        in_valid = 1'b0;
        chk("mr_full", 64'(b32.in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mr_in_ready_rst", 64'(b32.in_ready), 64'd0);
        edge1();
        chk("mr_out_valid_rst", 64'(b32.out_valid), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mr_in_ready_after", 64'(b32.in_ready), 64'd1);
        seen_valid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (b32.out_valid || b64.out_valid) seen_valid++;
        end
        chk("mr_no_stale", 64'(seen_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
